// File: rtl/key_debouncer_pkg.sv
// -----------------------------------------------------------------------------
// key_debouncer_pkg
//   Shared definitions for the push-button conditioning front-end: the per-key
//   FSM state encoding and small constant helpers for sizing counters.
//   Also imported by the counter/display benches that decode the key FSM.
// -----------------------------------------------------------------------------
package key_debouncer_pkg;

  localparam int KEY_STATE_W = 2;

  typedef enum logic [KEY_STATE_W-1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESS_CHK = 2'd1,
    ST_HELD      = 2'd2,
    ST_REL_CHK   = 2'd3
  } key_state_e;

  // Bits needed for a counter that runs 0 .. value-1. Never less than one bit,
  // so degenerate parameter values still give a legal vector.
  function automatic int cnt_width(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// -----------------------------------------------------------------------------
// key_debounce_ch
//   One key channel: 2-flop synchroniser, debounce FSM with a stable-time
//   counter, auto-repeat timer and registered single-cycle strobes.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   IDLE       | key released and accepted as released
//   PRESS_CHK  | raw shows pressed, waiting DEBOUNCE_CYCLES stable cycles
//   HELD       | press accepted; repeat timer running
//   REL_CHK    | raw shows released, waiting DEBOUNCE_CYCLES stable cycles
//
// Ports
//   clk100_i       in   system clock
//   rst_i          in   asynchronous reset, active-high
//   key_i          in   raw asynchronous key pin
//   key_level_o    out  debounced state, 1 = pressed
//   key_press_o    out  1-cycle strobe on accepted press
//   key_release_o  out  1-cycle strobe on accepted release
//   key_repeat_o   out  1-cycle strobe per auto-repeat tick
// -----------------------------------------------------------------------------
module key_debounce_ch
  import key_debouncer_pkg::*;
#(
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic clk100_i,
  input  logic rst_i,
  input  logic key_i,
  output logic key_level_o,
  output logic key_press_o,
  output logic key_release_o,
  output logic key_repeat_o
);

  localparam int CNT_W  = cnt_width(DEBOUNCE_CYCLES);
  localparam int RCNT_W = cnt_width(max_int(REPEAT_DELAY, REPEAT_PERIOD));
  localparam bit REP_EN = (REPEAT_DELAY > 0);

  localparam logic [CNT_W-1:0]  DEB_TC = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCNT_W-1:0] DLY_TC = RCNT_W'(REP_EN ? REPEAT_DELAY - 1 : 0);
  localparam logic [RCNT_W-1:0] PER_TC = RCNT_W'(REPEAT_PERIOD - 1);

  logic [1:0]        sync_q;
  logic              raw;
  key_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d, rcnt_tc;
  logic              armed_q, armed_d;
  logic              rcnt_hit;
  logic              level_d, press_d, release_d, repeat_d;

  assign raw = ACTIVE_LOW ? ~sync_q[1] : sync_q[1];

  // State register, counters and registered outputs. Sync flops reset to the
  // inactive pin level so leaving reset never looks like a press.
  always_ff @(posedge clk100_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q        <= {2{ACTIVE_LOW}};
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      rcnt_q        <= '0;
      armed_q       <= 1'b0;
      key_level_o   <= 1'b0;
      key_press_o   <= 1'b0;
      key_release_o <= 1'b0;
      key_repeat_o  <= 1'b0;
    end else begin
      sync_q        <= {sync_q[0], key_i};
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rcnt_q        <= rcnt_d;
      armed_q       <= armed_d;
      key_level_o   <= level_d;
      key_press_o   <= press_d;
      key_release_o <= release_d;
      key_repeat_o  <= repeat_d;
    end
  end

  // Next-state logic. The terminal-count compare precedes the increment, so
  // the debounce counter never exceeds DEBOUNCE_CYCLES-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (raw) begin
          state_d = ST_PRESS_CHK;
          cnt_d   = '0;
        end
      end
      ST_PRESS_CHK: begin
        if (!raw) begin
          state_d = ST_IDLE;
        end else if (cnt_q == DEB_TC) begin
          state_d = ST_HELD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (!raw) begin
          state_d = ST_REL_CHK;
          cnt_d   = '0;
        end
      end
      ST_REL_CHK: begin
        if (raw) begin
          state_d = ST_HELD;
        end else if (cnt_q == DEB_TC) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Repeat timer. armed selects between the initial delay and the period.
  // It only advances in HELD, so a release bounce (REL_CHK and back) pauses
  // it rather than restarting it. Reload on the hit means it never wraps.
  assign rcnt_tc = armed_q ? PER_TC : DLY_TC;

  always_comb begin
    rcnt_d   = rcnt_q;
    armed_d  = armed_q;
    rcnt_hit = 1'b0;
    if (REP_EN) begin
      if ((state_q == ST_PRESS_CHK) && (state_d == ST_HELD)) begin
        rcnt_d  = '0;
        armed_d = 1'b0;
      end else if (state_q == ST_HELD) begin
        if (rcnt_q == rcnt_tc) begin
          rcnt_d   = '0;
          armed_d  = 1'b1;
          rcnt_hit = 1'b1;
        end else begin
          rcnt_d = rcnt_q + RCNT_W'(1);
        end
      end
    end
  end

  // Output decode. Each strobe belongs to a distinct current state, so they
  // are mutually exclusive by construction.
  always_comb begin
    level_d   = (state_d == ST_HELD) || (state_d == ST_REL_CHK);
    press_d   = (state_q == ST_PRESS_CHK) && (state_d == ST_HELD);
    release_d = (state_q == ST_REL_CHK) && (state_d == ST_IDLE);
    repeat_d  = rcnt_hit;
  end

endmodule

// File: rtl/key_debouncer.sv
// -----------------------------------------------------------------------------
// key_debouncer
//   Conditioning front-end for the board push-buttons: N_KEYS independent
//   channels, each producing a clean level and press/release/repeat strobes
//   in the clk100_i domain.
//
// Ports
//   clk100_i       in   1       system clock, 100 MHz
//   rst_i          in   1       asynchronous reset, active-high
//   key_i          in   N_KEYS  raw asynchronous key pins
//   key_level_o    out  N_KEYS  debounced state, 1 = pressed
//   key_press_o    out  N_KEYS  1-cycle strobe on accepted press
//   key_release_o  out  N_KEYS  1-cycle strobe on accepted release
//   key_repeat_o   out  N_KEYS  1-cycle strobe per auto-repeat tick
// -----------------------------------------------------------------------------
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int N_KEYS          = 2,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic              clk100_i,
  input  logic              rst_i,
  input  logic [N_KEYS-1:0] key_i,
  output logic [N_KEYS-1:0] key_level_o,
  output logic [N_KEYS-1:0] key_press_o,
  output logic [N_KEYS-1:0] key_release_o,
  output logic [N_KEYS-1:0] key_repeat_o
);

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_debounce_ch #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk100_i      (clk100_i),
      .rst_i         (rst_i),
      .key_i         (key_i[g]),
      .key_level_o   (key_level_o[g]),
      .key_press_o   (key_press_o[g]),
      .key_release_o (key_release_o[g]),
      .key_repeat_o  (key_repeat_o[g])
    );
  end

endmodule

// File: tb/tb_key_debouncer.sv
// -----------------------------------------------------------------------------
// tb_key_debouncer
//   Directed bench for key_debouncer with short timing parameters.
//   cyc counts rising edges; inputs change #1 after edge cyc, so the first
//   edge to sample a change is cyc+1 and a clean press strobes at cyc+7
//   (two synchroniser edges, entry to PRESS_CHK, four stable cycles).
// -----------------------------------------------------------------------------
module tb_key_debouncer;

  localparam int N_KEYS = 2;

  logic              clk100 = 1'b0;
  logic              rst    = 1'b1;
  logic [N_KEYS-1:0] key    = 2'b11;
  logic [N_KEYS-1:0] key_level, key_press, key_release, key_repeat;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  int pq0[$], pq1[$], rq0[$], tq0[$], tq1[$];
  int e[$];
  int t0, p, r, b, c, t, q;

  always #5 clk100 = ~clk100;

  always @(posedge clk100) cyc <= cyc + 1;

  always @(negedge clk100) begin
    if (key_press[0])   pq0.push_back(cyc);
    if (key_press[1])   pq1.push_back(cyc);
    if (key_release[0]) rq0.push_back(cyc);
    if (key_repeat[0])  tq0.push_back(cyc);
    if (key_repeat[1])  tq1.push_back(cyc);
  end

  key_debouncer #(
    .N_KEYS          (N_KEYS),
    .ACTIVE_LOW      (1'b1),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (8),
    .REPEAT_PERIOD   (3)
  ) dut (
    .clk100_i      (clk100),
    .rst_i         (rst),
    .key_i         (key),
    .key_level_o   (key_level),
    .key_press_o   (key_press),
    .key_release_o (key_release),
    .key_repeat_o  (key_repeat)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic chk_q(input string tag, input int got[$], input int exp[$]);
    chk({tag, "_count"}, got.size(), exp.size());
    foreach (exp[i]) chk(tag, (i < got.size()) ? got[i] : -1, exp[i]);
  endtask

  task automatic step();
    @(posedge clk100);
    #1;
  endtask

  task automatic step_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic clear_logs();
    pq0.delete(); pq1.delete(); rq0.delete(); tq0.delete(); tq1.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_level"},   key_level,   0);
    chk({tag, "_press"},   key_press,   0);
    chk({tag, "_release"}, key_release, 0);
    chk({tag, "_repeat"},  key_repeat,  0);
  endtask

  initial begin
    // Reset state
    repeat (3) step();
    chk_all_zero("rst");
    rst = 1'b0;
    repeat (5) step();
    chk_all_zero("idle");
    chk("idle_no_press", pq0.size() + pq1.size(), 0);
    clear_logs();

    // Clean press on key 0, then repeat with a mid-hold release glitch,
    // then a clean release.
    t0 = cyc;
    key[0] = 1'b0;
    step_to(t0 + 6);
    chk("t1_level_before", key_level[0], 0);
    step_to(t0 + 7);
    chk("t1_press", key_press[0], 1);
    chk("t1_level", key_level[0], 1);
    step();
    chk("t1_press_one_cycle", key_press[0], 0);
    p = t0 + 7;

    // Glitch: key high after edges p+10..p+11, FSM sees it at p+13,p+14,
    // timer paused at p+14,p+15 so the tick due at p+14 lands at p+16.
    step_to(p + 10);
    key[0] = 1'b1;
    step_to(p + 12);
    key[0] = 1'b0;
    step_to(p + 23);
    key[0] = 1'b1;
    step_to(p + 29);
    chk("t4_level_before", key_level[0], 1);
    step_to(p + 30);
    chk("t4_release", key_release[0], 1);
    chk("t4_level", key_level[0], 0);
    step_to(p + 45);
    e = {p};
    chk_q("t1_press_log", pq0, e);
    e = {p + 8, p + 11, p + 16, p + 19, p + 22, p + 25};
    chk_q("t3_repeat_log", tq0, e);
    e = {p + 30};
    chk_q("t4_release_log", rq0, e);
    clear_logs();

    // Bounce: low 3 cycles, high 1, then low steady from after edge b+4.
    b = cyc;
    key[0] = 1'b0;
    step_to(b + 3);
    key[0] = 1'b1;
    step_to(b + 4);
    key[0] = 1'b0;
    step_to(b + 30);
    e = {b + 11};
    chk_q("t2_press_log", pq0, e);
    chk("t2_no_release", rq0.size(), 0);
    e = {b + 19, b + 22, b + 25, b + 28};
    chk_q("t2_repeat_log", tq0, e);
    c = cyc;
    key[0] = 1'b1;
    step_to(c + 12);
    e = {c + 7};
    chk_q("t2_release_log", rq0, e);
    clear_logs();

    // Both keys pressed in the same cycle.
    t = cyc;
    key = 2'b00;
    step_to(t + 7);
    chk("t5_press_both", key_press, 2'b11);
    chk("t5_level_both", key_level, 2'b11);
    step_to(t + 9);
    e = {t + 7};
    chk_q("t5_press0_log", pq0, e);
    chk_q("t5_press1_log", pq1, e);

    // Reset while held: everything clears immediately, keys still low are
    // re-debounced as a fresh press 7 edges after deassert (edge q+1 is the
    // first to sample the pin, press six edges after that).
    step_to(t + 12);
    rst = 1'b1;
    #1;
    chk("t6_level_async", key_level, 0);
    step_to(t + 15);
    chk_all_zero("t6_in_rst");
    clear_logs();
    rst = 1'b0;
    q = cyc;
    step_to(q + 6);
    chk("t6_no_early_press", key_press, 0);
    chk("t6_level_low", key_level, 0);
    step_to(q + 7);
    chk("t6_fresh_press", key_press, 2'b11);
    step_to(q + 10);
    e = {q + 7};
    chk_q("t6_press0_log", pq0, e);
    chk_q("t6_press1_log", pq1, e);
    chk("t6_no_release", rq0.size(), 0);
    chk("t6_no_repeat", tq0.size() + tq1.size(), 0);

    key = 2'b11;
    repeat (20) step();
    chk("end_level", key_level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
